powlib_busarb: RTL and testbench

//  Single-clock N-to-1 bus arbiter lane for the next-generation crossbar. It merges B_WRS

---
 rtl/powlib_busarb_pkg.sv | 21 ++
 rtl/powlib_busarb_if.sv | 32 +++
 rtl/powlib_busarb_skid.sv | 59 +++++
 rtl/powlib_busarb.sv | 147 ++++++++++++++
 tb/tb_powlib_busarb.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/powlib_busarb_pkg.sv
// Shared types and helpers for the powlib bus arbiter lane.
// Arbitration mode codes, FSM state type and a ceil-log2 helper.
package powlib_busarb_pkg;

  localparam int POWLIB_ARB_FIXED = 0;
  localparam int POWLIB_ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } arb_st_t;

  function automatic int powlib_clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/powlib_busarb_if.sv
// Write-side and read-side bundle of the arbiter lane.
// slave = arbiter view, master = environment view.
interface powlib_busarb_if #(
  parameter int B_WRS = 4,
  parameter int B_AW  = 2,
  parameter int B_DW  = 4
);
  import powlib_busarb_pkg::*;

  localparam int B_SW = powlib_clogb2(B_WRS);

  logic [B_WRS*B_DW-1:0] wrdatas;
  logic [B_WRS*B_AW-1:0] wraddrs;
  logic [B_WRS-1:0]      wrvlds;
  logic [B_WRS-1:0]      wrrdys;
  logic [B_DW-1:0]       rddata;
  logic [B_AW-1:0]       rdaddr;
  logic                  rdvld;
  logic                  rdrdy;
  logic [B_SW-1:0]       rdsel;

  modport slave (
    input  wrdatas, wraddrs, wrvlds, rdrdy,
    output wrrdys, rddata, rdaddr, rdvld, rdsel
  );

  modport master (
    output wrdatas, wraddrs, wrvlds, rdrdy,
    input  wrrdys, rddata, rdaddr, rdvld, rdsel
  );

endinterface

// File: rtl/powlib_busarb_skid.sv
// Two-entry skid buffer; full is registered so the write side
// never depends combinationally on the read-side ready.
module powlib_busarb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_wrdata,
  input  logic         i_wrvld,
  output logic [W-1:0] o_rddata,
  output logic         o_rdvld,
  input  logic         i_rdrdy,
  output logic         o_full
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic         r_full;
  logic [1:0]   r_cnt;
  logic [1:0]   w_cnt_nxt;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_wrvld && !r_full;
  assign w_pop  = (r_cnt != 2'd0) && i_rdrdy;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case (1'b1)
      w_push && !w_pop: w_cnt_nxt = r_cnt + 2'd1;
      !w_push && w_pop: w_cnt_nxt = r_cnt - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '{default: '0};
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_wrdata;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == 2'd2);
    end
  end

  assign o_rddata = r_mem[r_rp];
  assign o_rdvld  = (r_cnt != 2'd0);
  assign o_full   = r_full;

endmodule

// File: rtl/powlib_busarb.sv
// N-to-1 windowed bus arbiter lane: fixed or round-robin grant
// with optional burst lock, feeding a 2-entry skid buffer.
module powlib_busarb
  import powlib_busarb_pkg::*;
#(
  parameter int B_WRS  = 4,
  parameter int B_AW   = 2,
  parameter int B_DW   = 4,
  parameter int MODE   = POWLIB_ARB_RR,
  parameter int BURST  = 1,
  parameter int B_BASE = 0,
  parameter int B_SIZE = 3
) (
  input logic           clk,
  input logic           rst,
  powlib_busarb_if.slave bus
);

  localparam int SW = powlib_clogb2(B_WRS);
  localparam int CW = powlib_clogb2(BURST + 1);
  localparam int PW = SW + B_AW + B_DW;

  if ((B_BASE + B_SIZE >= 2**B_AW) || (BURST < 1)) begin : g_chk
    $error("powlib_busarb: bad window or BURST");
  end

  function automatic logic [SW-1:0] nxt_idx(input logic [SW-1:0] v);
    return (int'(v) == B_WRS - 1) ? '0 : SW'(int'(v) + 1);
  endfunction

  function automatic logic [SW:0] pick(
    input logic [B_WRS-1:0] r,
    input logic [SW-1:0]    s
  );
    logic [SW:0] res;
    int j;
    res = '0;
    for (int k = 0; k < B_WRS; k++) begin
      j = int'(s) + k;
      if (j >= B_WRS) j = j - B_WRS;
      if (!res[SW] && r[j]) res = {1'b1, SW'(j)};
    end
    return res;
  endfunction

  arb_st_t        r_st, w_st_nxt;
  logic [SW-1:0]  r_own, w_own_nxt;
  logic [SW-1:0]  r_ptr, w_ptr_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;

  logic [B_WRS-1:0] w_in;
  logic [B_WRS-1:0] w_req;
  logic [SW-1:0]    w_start;
  logic [SW:0]      w_pick;
  logic [SW-1:0]    w_g;
  logic             w_hold;
  logic             w_have;
  logic             w_xfer;
  logic             w_full;
  logic [PW-1:0]    w_wr;
  logic [PW-1:0]    w_rd;

  always_comb begin
    for (int i = 0; i < B_WRS; i++) begin
      w_in[i]  = (int'(bus.wraddrs[i*B_AW +: B_AW]) >= B_BASE) &&
                 (int'(bus.wraddrs[i*B_AW +: B_AW]) <= B_BASE + B_SIZE);
      w_req[i] = bus.wrvlds[i] && w_in[i];
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_own_nxt = r_own;
    w_cnt_nxt = r_cnt;
    w_ptr_nxt = r_ptr;
    w_start   = r_ptr;
    w_hold    = (r_st == ST_LOCK) && w_req[r_own];
    // owner went quiet: release the lock and re-arbitrate this cycle
    if ((r_st == ST_LOCK) && !w_req[r_own]) begin
      w_st_nxt  = ST_IDLE;
      w_ptr_nxt = nxt_idx(r_own);
      w_start   = nxt_idx(r_own);
    end
    if (MODE == POWLIB_ARB_FIXED) w_start = '0;
    w_pick = pick(w_req, w_start);
    w_have = w_hold || w_pick[SW];
    w_g    = w_hold ? r_own : w_pick[SW-1:0];
    w_xfer = w_have && !w_full;
    unique case (1'b1)
      w_xfer && w_hold: begin
        if (r_cnt == CW'(BURST - 1)) begin
          w_st_nxt  = ST_IDLE;
          w_ptr_nxt = nxt_idx(r_own);
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      w_xfer && !w_hold && (BURST == 1): begin
        w_ptr_nxt = nxt_idx(w_g);
      end
      w_xfer && !w_hold && (BURST != 1): begin
        w_st_nxt  = ST_LOCK;
        w_own_nxt = w_g;
        w_cnt_nxt = CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= ST_IDLE;
      r_own <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_own <= w_own_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign bus.wrrdys = ~w_in |
    ((w_have && !w_full) ? (B_WRS'(1) << w_g) : '0);

  assign w_wr = {w_g,
                 bus.wraddrs[w_g*B_AW +: B_AW],
                 bus.wrdatas[w_g*B_DW +: B_DW]};

  powlib_busarb_skid #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_wrdata (w_wr),
    .i_wrvld  (w_xfer),
    .o_rddata (w_rd),
    .o_rdvld  (bus.rdvld),
    .i_rdrdy  (bus.rdrdy),
    .o_full   (w_full)
  );

  assign {bus.rdsel, bus.rdaddr, bus.rddata} = w_rd;

endmodule

// File: tb/tb_powlib_busarb.sv
// Directed bench for powlib_busarb: four lanes in different
// configurations, driven after posedge and checked on negedge.
module tb_powlib_busarb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  powlib_busarb_if #(.B_WRS(4), .B_AW(2), .B_DW(4)) if0 ();
  powlib_busarb_if #(.B_WRS(4), .B_AW(2), .B_DW(4)) if1 ();
  powlib_busarb_if #(.B_WRS(4), .B_AW(2), .B_DW(4)) if2 ();
  powlib_busarb_if #(.B_WRS(4), .B_AW(2), .B_DW(4)) if3 ();

  powlib_busarb #(.MODE(1), .BURST(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  powlib_busarb #(.MODE(1), .BURST(4)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  powlib_busarb #(.MODE(0), .BURST(1)) u2 (
    .clk(clk), .rst(rst), .bus(if2));
  powlib_busarb #(.MODE(1), .BURST(1), .B_BASE(2), .B_SIZE(0)) u3 (
    .clk(clk), .rst(rst), .bus(if3));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp)
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if0.wrvlds = '0; if0.wraddrs = '0; if0.wrdatas = '0; if0.rdrdy = 1'b0;
    if1.wrvlds = '0; if1.wraddrs = '0; if1.wrdatas = '0; if1.rdrdy = 1'b0;
    if2.wrvlds = '0; if2.wraddrs = '0; if2.wrdatas = '0; if2.rdrdy = 1'b0;
    if3.wrvlds = '0; if3.wraddrs = '0; if3.wrdatas = '0; if3.rdrdy = 1'b0;
  endtask

  task automatic do_rst();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int g2 [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
  int r5 [9]  = '{1, 2, 0, 0, 0, 0, 4, 8, 1};

  initial begin
    idle_all();
    #1 rst = 1'b1;
    #1;
    chk("rst_rdvld", int'(if0.rdvld), 0);
    chk("rst_rddata", int'(if0.rddata), 0);
    chk("rst_rdaddr", int'(if0.rdaddr), 0);
    chk("rst_rdsel", int'(if0.rdsel), 0);
    tick();
    rst = 1'b0;

    // 1: round-robin, no lock, all sources streaming
    if0.wrvlds = 4'b1111;
    if0.wraddrs = 8'b11_10_01_00;
    if0.wrdatas = 16'h8765;
    if0.rdrdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("t1_rdy", int'(if0.wrrdys), 1 << (k % 4));
      if (k > 0) begin
        chk("t1_vld", int'(if0.rdvld), 1);
        chk("t1_sel", int'(if0.rdsel), (k - 1) % 4);
        chk("t1_dat", int'(if0.rddata), ((k - 1) % 4) + 5);
      end
      tick();
    end

    // 2: round-robin with 4-beat burst lock
    do_rst();
    if1.wrvlds = 4'b0101;
    if1.wraddrs = 8'b11_10_01_00;
    if1.wrdatas = 16'h4321;
    if1.rdrdy = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k < 12) chk("t2_rdy", int'(if1.wrrdys), 1 << g2[k]);
      if (k > 0) begin
        chk("t2_vld", int'(if1.rdvld), 1);
        chk("t2_sel", int'(if1.rdsel), g2[k-1]);
      end
      tick();
    end

    // 3: fixed priority
    do_rst();
    if2.wrvlds = 4'b0011;
    if2.wraddrs = 8'b11_10_01_00;
    if2.wrdatas = 16'h4321;
    if2.rdrdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_rdy", int'(if2.wrrdys), 1);
      if (k > 0) chk("t3_sel", int'(if2.rdsel), 0);
      tick();
    end
    if2.wrvlds = 4'b0010;
    @(negedge clk);
    chk("t3_rdy1", int'(if2.wrrdys), 2);
    tick();
    @(negedge clk);
    chk("t3_vld1", int'(if2.rdvld), 1);
    chk("t3_sel1", int'(if2.rdsel), 1);
    chk("t3_dat1", int'(if2.rddata), 2);

    // 4: address window [2,2]
    do_rst();
    if3.wrvlds = 4'b0010;
    if3.wraddrs = 8'b00_10_11_10;
    if3.wrdatas = 16'h00A0;
    if3.rdrdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_rdy", int'(if3.wrrdys), 4'b1010);
      chk("t4_vld", int'(if3.rdvld), 0);
      tick();
    end
    if3.wraddrs = 8'b00_10_10_10;
    @(negedge clk);
    chk("t4_rdy2", int'(if3.wrrdys), 4'b1010);
    tick();
    @(negedge clk);
    chk("t4_vld2", int'(if3.rdvld), 1);
    chk("t4_adr2", int'(if3.rdaddr), 2);
    chk("t4_sel2", int'(if3.rdsel), 1);
    chk("t4_dat2", int'(if3.rddata), 10);

    // 5: backpressure fills the skid, then drains in order
    do_rst();
    if0.wrvlds = 4'b1111;
    if0.wraddrs = 8'b11_10_01_00;
    if0.wrdatas = 16'hCBA9;
    if0.rdrdy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) if0.rdrdy = 1'b1;
      @(negedge clk);
      chk("t5_rdy", int'(if0.wrrdys), r5[k]);
      chk("t5_vld", int'(if0.rdvld), (k > 0) ? 1 : 0);
      if (k > 0 && k < 5) chk("t5_hsel", int'(if0.rdsel), 0);
      if (k >= 5) begin
        chk("t5_sel", int'(if0.rdsel), k - 5);
        chk("t5_dat", int'(if0.rddata), 9 + k - 5);
      end
      tick();
    end

    // 6: async reset mid-burst
    do_rst();
    if1.wrvlds = 4'b0101;
    if1.wraddrs = 8'b11_10_01_00;
    if1.wrdatas = 16'h4321;
    if1.rdrdy = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    @(negedge clk);
    chk("t6_pre_vld", int'(if1.rdvld), 1);
    chk("t6_pre_sel", int'(if1.rdsel), 2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_vld", int'(if1.rdvld), 0);
    chk("t6_rst_sel", int'(if1.rdsel), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rdy", int'(if1.wrrdys), 1);
    chk("t6_vld0", int'(if1.rdvld), 0);
    tick();
    @(negedge clk);
    chk("t6_vld1", int'(if1.rdvld), 1);
    chk("t6_sel1", int'(if1.rdsel), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
